show_sw: RTL and testbench



---
 rtl/show_sw_pkg.sv | 28 ++
 rtl/show_sw_seg7_decode.sv | 35 +++
 rtl/show_sw.sv | 51 +++++
 tb/tb_show_sw.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/show_sw_pkg.sv
// Shared constants for the switch-to-display front end: 7-segment codes
// ({a,b,c,d,e,f,g}, active high), digit-select and LED idle patterns.
package show_sw_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h1F;
    localparam logic [6:0] SEG_C     = 7'h4E;
    localparam logic [6:0] SEG_D     = 7'h3D;
    localparam logic [6:0] SEG_E     = 7'h4F;
    localparam logic [6:0] SEG_F     = 7'h47;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Leftmost digit only (bit 7), active low.
    localparam logic [7:0] CSN_DIGIT0 = 8'b0111_1111;
    localparam logic [7:0] CSN_BLANK  = 8'hFF;
    localparam logic [3:0] LED_OFF    = 4'hF;

endpackage

// File: rtl/show_sw_seg7_decode.sv
// Combinational 4-bit to 7-segment decoder. SHOW_SW_HEX_EN selects the full
// hex table; without it values 10-15 are shown blank.
import show_sw_pkg::*;

module seg7_decode (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
`ifdef SHOW_SW_HEX_EN
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/show_sw.sv
// Switch bank to 7-segment/LED front end: current value (~switch) on the
// leftmost digit, previous value on active-low LEDs. Option: SHOW_SW_HEX_EN.
import show_sw_pkg::*;

module show_sw (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] switch,
    output logic [7:0] num_csn,
    output logic [6:0] num_a_g,
    output logic [3:0] led
);

    logic [3:0] cur_val;
    logic [3:0] prev_val;
    logic       loaded;
    logic [3:0] sw_val;
    logic [6:0] seg_code;

    assign sw_val = ~switch;

    seg7_decode u_decode (
        .value (cur_val),
        .seg   (seg_code)
    );

    // NOTE: all state uses non-blocking assignment so prev_val captures the
    // old cur_val on the same edge that cur_val takes the new switch value.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_val  <= 4'h0;
            prev_val <= 4'h0;
            loaded   <= 1'b0;
            num_csn  <= CSN_BLANK;
            num_a_g  <= SEG_BLANK;
            led      <= LED_OFF;
        end else begin
            cur_val <= sw_val;
            if (sw_val != cur_val)
                prev_val <= cur_val;
            loaded <= 1'b1;
            // Keep the display blank until cur_val holds a sampled value.
            if (loaded) begin
                num_csn <= CSN_DIGIT0;
                num_a_g <= seg_code;
                led     <= ~prev_val;
            end
        end
    end

endmodule

// File: tb/tb_show_sw.sv
// Scoreboard bench for show_sw: stimulus pushes expected outputs tagged with
// the cycle they are due; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_show_sw;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] switch;
    logic [7:0] num_csn;
    logic [6:0] num_a_g;
    logic [3:0] led;

    show_sw dut (
        .clk     (clk),
        .resetn  (resetn),
        .switch  (switch),
        .num_csn (num_csn),
        .num_a_g (num_a_g),
        .led     (led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] csn;
        logic [6:0] seg;
        logic [3:0] led;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every entry whose due cycle has arrived.
    exp_t e;
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: missed due cycle %0d at cycle %0d", e.name, e.due, cyc);
            end else begin
                check({e.name, ".csn"}, 32'(num_csn), 32'(e.csn));
                check({e.name, ".seg"}, 32'(num_a_g), 32'(e.seg));
                check({e.name, ".led"}, 32'(led),     32'(e.led));
            end
        end
    end

    typedef struct {
        logic [3:0] sw;
        logic [6:0] seg_hex;
        logic [6:0] seg_dec;
        logic [3:0] led;
        string      name;
    } vec_t;

    function automatic logic [6:0] pick(input vec_t v);
`ifdef SHOW_SW_HEX_EN
        return v.seg_hex;
`else
        return v.seg_dec;
`endif
    endfunction

    logic [6:0] old_seg;
    logic [3:0] old_led;

    task automatic push(input int due, input logic [7:0] csn, input logic [6:0] seg,
                        input logic [3:0] l, input string name);
        exp_t x;
        x.due = due; x.csn = csn; x.seg = seg; x.led = l; x.name = name;
        sb.push_back(x);
    endtask

    // Change switch just after an edge K: outputs still old at K+1, new at K+2.
    task automatic apply(input vec_t v, input int hold);
        int k;
        @(posedge clk); #1;
        switch = v.sw;
        k = cyc;
        push(k + 1, 8'h7F, old_seg, old_led, {v.name, "_lat1"});
        push(k + 2, 8'h7F, pick(v), v.led, {v.name, "_lat2"});
        old_seg = pick(v);
        old_led = v.led;
        repeat (hold) @(posedge clk);
    endtask

    vec_t run1[7];
    vec_t post_rst;

    initial begin
        int k;
        run1[0] = '{4'h8, 7'h70, 7'h70, 4'hF, "sw8"};
        run1[1] = '{4'h9, 7'h5F, 7'h5F, 4'h8, "sw9"};
        run1[2] = '{4'hE, 7'h30, 7'h30, 4'h9, "swE"};
        run1[3] = '{4'h2, 7'h3D, 7'h00, 4'hE, "sw2"};
        run1[4] = '{4'h0, 7'h47, 7'h00, 4'h2, "sw0"};
        run1[5] = '{4'hB, 7'h33, 7'h33, 4'h0, "swB"};
        run1[6] = '{4'h3, 7'h4E, 7'h00, 4'hB, "sw3"};
        post_rst = '{4'h8, 7'h70, 7'h70, 4'h3, "rst_sw8"};

        resetn = 1'b0;
        switch = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        push(cyc, 8'hFF, 7'h00, 4'hF, "reset");

        @(posedge clk); #1;
        resetn = 1'b1;
        k = cyc;
        push(k + 1, 8'hFF, 7'h00, 4'hF, "release1");
        push(k + 2, 8'h7F, 7'h7E, 4'hF, "release2");
        old_seg = 7'h7E;
        old_led = 4'hF;
        repeat (4) @(posedge clk);

        foreach (run1[i]) apply(run1[i], 10);

        repeat (50) @(posedge clk);
        #1;
        push(cyc, 8'h7F, pick(run1[6]), 4'hB, "hold50");

        // Mid-run reset with switch left at 4'h3.
        @(posedge clk); #1;
        resetn = 1'b0;
        push(cyc + 1, 8'hFF, 7'h00, 4'hF, "midreset");
        @(posedge clk); #1;
        resetn = 1'b1;
        k = cyc;
        push(k + 1, 8'hFF, 7'h00, 4'hF, "rel_mid1");
        push(k + 2, 8'h7F, pick(run1[6]), 4'hF, "rel_mid2");
        old_seg = pick(run1[6]);
        old_led = 4'hF;
        repeat (4) @(posedge clk);

        apply(post_rst, 10);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries never compared", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
